// File: rtl/muldiv_scheduler.sv
// Round-robin two-port front-end for the shared multi-cycle alu_muldiv unit; one outstanding request per port.
// Latency: MUL accept->response 7 cycles (2 + unit latency); a cache hit under MULDIV_SCHED_RESULT_CACHE_EN answers at T+1.
// Backpressure: a port holding an unconsumed response is not granted; flush drains the unit without a response.
module muldiv_scheduler #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [1:0][2:0]  req_op_i,
    input  logic [1:0][31:0] req_num1_i,
    input  logic [1:0][31:0] req_num2_i,
    output logic [1:0]       resp_valid_o,
    input  logic [1:0]       resp_ready_i,
    output logic [1:0][31:0] resp_result_o,
    output logic [2:0]       md_op_o,
    output logic [31:0]      md_num1_o,
    output logic [31:0]      md_num2_o,
    output logic             md_valid_o,
    input  logic [31:0]      md_result_i,
    input  logic             md_busy_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr;
    logic             r_owner;
    logic [2:0]       r_md_op;
    logic [31:0]      r_md_num1;
    logic [31:0]      r_md_num2;
    logic [1:0]       r_resp_vld;
    logic [1:0][31:0] r_resp_res;

    logic [1:0]       w_elig;
    logic             w_grant;
    logic             w_port;
    logic             w_hit;
    logic             w_issue;
    logic             w_capture;
    logic [2:0]       w_sel_op;
    logic [31:0]      w_sel_num1;
    logic [31:0]      w_sel_num2;
    logic [31:0]      w_hit_res;

    // Grant depends only on registered state and request inputs, never on md_*_i.
    always_comb begin
        w_elig     = req_valid_i & ~r_resp_vld;
        w_grant    = (r_state == S_IDLE) && !flush_i && (w_elig != 2'b00);
        w_port     = (w_elig == 2'b11) ? r_ptr : w_elig[1];
        w_sel_op   = req_op_i[w_port];
        w_sel_num1 = req_num1_i[w_port];
        w_sel_num2 = req_num2_i[w_port];
        w_issue    = w_grant && !w_hit;
        w_capture  = (r_state == S_WAIT) && !flush_i && !md_busy_i;
    end

`ifdef MULDIV_SCHED_RESULT_CACHE_EN
    logic        r_c_vld;
    logic [2:0]  r_c_op;
    logic [31:0] r_c_num1;
    logic [31:0] r_c_num2;
    logic [31:0] r_c_res;

    // Survives flush on purpose: the unit's result is still correct for those operands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_c_vld  <= 1'b0;
            r_c_op   <= '0;
            r_c_num1 <= '0;
            r_c_num2 <= '0;
            r_c_res  <= '0;
        end else if (w_capture) begin
            r_c_vld  <= 1'b1;
            r_c_op   <= r_md_op;
            r_c_num1 <= r_md_num1;
            r_c_num2 <= r_md_num2;
            r_c_res  <= md_result_i;
        end
    end

    assign w_hit     = r_c_vld && (r_c_op == w_sel_op) &&
                       (r_c_num1 == w_sel_num1) && (r_c_num2 == w_sel_num2);
    assign w_hit_res = r_c_res;
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = flush_i ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (flush_i)         w_state_nxt = S_DRAIN;
                else if (!md_busy_i) w_state_nxt = S_IDLE;
            end
            S_DRAIN: if (!md_busy_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_ptr     <= 1'(PRIO_INIT);
            r_owner   <= 1'b0;
            r_md_op   <= '0;
            r_md_num1 <= '0;
            r_md_num2 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) r_ptr <= ~w_port;
            if (w_issue) begin
                r_owner   <= w_port;
                r_md_op   <= w_sel_op;
                r_md_num1 <= w_sel_num1;
                r_md_num2 <= w_sel_num2;
            end
        end
    end

    // Flush wins over capture, so a result racing a flush is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_vld <= '0;
            r_resp_res <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (flush_i) begin
                    r_resp_vld[p] <= 1'b0;
                end else if (w_capture && (r_owner == 1'(p))) begin
                    r_resp_vld[p] <= 1'b1;
                    r_resp_res[p] <= md_result_i;
                end else if (w_grant && w_hit && (w_port == 1'(p))) begin
                    r_resp_vld[p] <= 1'b1;
                    r_resp_res[p] <= w_hit_res;
                end else if (r_resp_vld[p] && resp_ready_i[p]) begin
                    r_resp_vld[p] <= 1'b0;
                end
            end
        end
    end

    assign req_ready_o   = w_grant ? (w_port ? 2'b10 : 2'b01) : 2'b00;
    assign resp_valid_o  = r_resp_vld;
    assign resp_result_o = r_resp_res;
    assign md_op_o       = r_md_op;
    assign md_num1_o     = r_md_num1;
    assign md_num2_o     = r_md_num2;
    assign md_valid_o    = (r_state == S_ISSUE);

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench for muldiv_scheduler with a behavioural alu_muldiv (MUL busy 5 cycles, DIV busy 10 cycles).
module tb_muldiv_scheduler;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULHU = 3'b011, OP_DIV = 3'b100,
                           OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
`ifdef MULDIV_SCHED_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][2:0]  req_op_i;
    logic [1:0][31:0] req_num1_i;
    logic [1:0][31:0] req_num2_i;
    logic [1:0]       resp_valid_o;
    logic [1:0]       resp_ready_i;
    logic [1:0][31:0] resp_result_o;
    logic [2:0]       md_op_o;
    logic [31:0]      md_num1_o;
    logic [31:0]      md_num2_o;
    logic             md_valid_o;
    logic [31:0]      md_result_i;
    logic             md_busy_i;

    muldiv_scheduler #(.PRIO_INIT(0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_num1_i(req_num1_i), .req_num2_i(req_num2_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_result_o(resp_result_o),
        .md_op_o(md_op_o), .md_num1_o(md_num1_o), .md_num2_o(md_num2_o), .md_valid_o(md_valid_o),
        .md_result_i(md_result_i), .md_busy_i(md_busy_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (op)
            3'b000: p = sa * sb;
            3'b001: p = sa * sb;
            3'b010: p = sa * ub;
            3'b011: p = {32'b0, a} * {32'b0, b};
            default: p = '0;
        endcase
        case (op)
            3'b000: return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: return (b == 0) ? 32'hFFFFFFFF :
                           (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'($signed(a) / $signed(b));
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: return (b == 0) ? a :
                           (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    logic [3:0] m_cnt;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_cnt       <= '0;
            md_result_i <= '0;
        end else if (md_valid_o) begin
            m_cnt       <= md_op_o[2] ? 4'd9 : 4'd4;
            md_result_i <= alu_ref(md_op_o, md_num1_o, md_num2_o);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 4'd1;
        end
    end
    assign md_busy_i = md_valid_o || (m_cnt != 0);

    int n_cmp = 0;
    int n_fail = 0;
    int md_vld_cnt = 0;
    int t_grant = 0;
    int t_wait = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response handshake pops the port's oldest expectation.
    always @(negedge clk_i) begin
        if (md_valid_o) md_vld_cnt++;
        if (rst_ni && resp_valid_o[0] && resp_ready_i[0]) begin
            if (q0.size() == 0) chk("sb_p0_unexpected", q0.size() != 0, 1);
            else chk("sb_p0_result", resp_result_o[0], q0.pop_front());
        end
        if (rst_ni && resp_valid_o[1] && resp_ready_i[1]) begin
            if (q1.size() == 0) chk("sb_p1_unexpected", q1.size() != 0, 1);
            else chk("sb_p1_result", resp_result_o[1], q1.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push);
        int t0;
        bit got;
        req_valid_i[p] = 1'b1;
        req_op_i[p]    = op;
        req_num1_i[p]  = a;
        req_num2_i[p]  = b;
        if (push) begin
            if (p == 0) q0.push_back(exp);
            else        q1.push_back(exp);
        end
        t0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (req_ready_o[p]) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (got) begin
            chk("grant_onehot", req_ready_o, (p == 0) ? 2'b01 : 2'b10);
            t_grant = cyc;
            t_wait  = cyc - t0;
        end else begin
            chk("grant_timeout", req_ready_o[p], 1);
        end
        tick();
        req_valid_i[p] = 1'b0;
    endtask

    task automatic wait_resp(input int p, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            if (resp_valid_o[p]) begin
                t = cyc;
                break;
            end
            tick();
        end
        if (t < 0) begin
            chk("resp_timeout", resp_valid_o[p], 1);
            t = cyc;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_resp_result", {resp_result_o[1], resp_result_o[0]}, 0);
        chk("rst_md_valid", md_valid_o, 0);
        chk("rst_md_regs", {md_op_o, md_num1_o, md_num2_o}, 0);
        chk("rst_req_ready", req_ready_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, m0, tg;
        flush_i      = 1'b0;
        req_valid_i  = '0;
        req_op_i     = '0;
        req_num1_i   = '0;
        req_num2_i   = '0;
        resp_ready_i = 2'b11;

        do_reset();

        // Single MUL
        m0 = md_vld_cnt;
        send(0, OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
        chk("mul_accept_same_cycle", t_wait, 0);
        chk("mul_md_valid_t1", md_valid_o, 1);
        chk("mul_md_operands", {md_op_o, md_num1_o, md_num2_o}, {OP_MUL, 32'd7, 32'hFFFFFFFD});
        tick();
        chk("mul_md_valid_t2", md_valid_o, 0);
        chk("mul_md_held", md_num2_o, 32'hFFFFFFFD);
        wait_resp(0, 50, t);
        chk("mul_latency", t - t_grant, 7);
        chk("mul_result", resp_result_o[0], 32'hFFFFFFEB);
        chk("mul_md_valid_pulses", md_vld_cnt - m0, 1);
        tick();

        // Contention after reset: port0 favoured
        do_reset();
        req_valid_i = 2'b11;
        req_op_i[0] = OP_DIVU; req_num1_i[0] = 32'd100;        req_num2_i[0] = 32'd7;
        req_op_i[1] = OP_REM;  req_num1_i[1] = 32'hFFFFFFF9;   req_num2_i[1] = 32'd2;
        q0.push_back(32'd14);
        q1.push_back(32'hFFFFFFFF);
        #1;
        chk("contend_first_grant", req_ready_o, 2'b01);
        tg = cyc;
        tick();
        req_valid_i[0] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (req_ready_o[1]) break;
            tick();
        end
        chk("contend_second_grant", req_ready_o, 2'b10);
        chk("contend_grant_cycle", cyc - tg, 12);
        chk("divu_resp_at_t12", resp_valid_o[0], 1);
        tg = cyc;
        tick();
        req_valid_i[1] = 1'b0;
        wait_resp(1, 50, t);
        chk("rem_latency", t - tg, 12);
        tick();

        // Divide by zero
        send(1, OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);
        wait_resp(1, 50, t);
        chk("div0_result", resp_result_o[1], 32'hFFFFFFFF);
        send(1, OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1);
        wait_resp(1, 50, t);
        chk("remu0_result", resp_result_o[1], 32'd5);
        tick();

        // Flush in the second WAIT cycle of a DIV
        send(0, OP_DIV, 32'd20, 32'd3, 32'd0, 1'b0);
        tg = t_grant;
        tick();
        tick();
        flush_i        = 1'b1;
        req_valid_i[1] = 1'b1;
        req_op_i[1]    = OP_MUL; req_num1_i[1] = 32'd6; req_num2_i[1] = 32'd7;
        q1.push_back(32'd42);
        #1;
        chk("flush_blocks_grant", req_ready_o, 2'b00);
        tick();
        flush_i = 1'b0;
        for (int c = 4; c <= 12; c++) begin
            #1;
            chk("drain_grant_gate", req_ready_o, (c == 12) ? 2'b10 : 2'b00);
            chk("flush_no_resp", resp_valid_o, 2'b00);
            if (c < 12) tick();
        end
        tick();
        req_valid_i[1] = 1'b0;
        wait_resp(1, 50, t);
        tick();

        // Backpressure on port0
        resp_ready_i[0] = 1'b0;
        send(0, OP_MUL, 32'd2, 32'd3, 32'd6, 1'b1);
        wait_resp(0, 50, t);
        req_valid_i[0] = 1'b1;
        req_op_i[0] = OP_MUL; req_num1_i[0] = 32'd9; req_num2_i[0] = 32'd9;
        send(1, OP_MUL, 32'd3, 32'd4, 32'd12, 1'b1);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("bp_no_ready_p0", req_ready_o[0], 0);
            chk("bp_result_held", resp_result_o[0], 32'd6);
            chk("bp_valid_held", resp_valid_o[0], 1);
            tick();
        end
        req_valid_i[0]  = 1'b0;
        resp_ready_i[0] = 1'b1;
        tick();
        tick();

        // Repeated MULHU: cache hit when enabled
        do_reset();
        send(0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
        wait_resp(0, 50, t);
        chk("mulhu_first_latency", t - t_grant, 7);
        tick();
        m0 = md_vld_cnt;
        send(0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
        wait_resp(0, 50, t);
        chk("mulhu_second_latency", t - t_grant, CACHE ? 1 : 7);
        chk("mulhu_second_result", resp_result_o[0], 32'hFFFFFFFE);
        chk("mulhu_second_md_pulses", md_vld_cnt - m0, CACHE ? 0 : 1);

        repeat (3) tick();
        chk("sb_p0_drained", q0.size(), 0);
        chk("sb_p1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
